// File: rtl/arbitrate_pkg.sv
// Shared helpers for the stream arbiter: index width and wrap-around index arithmetic.
package arbitrate_pkg;

    function automatic int iw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int next_idx(input int i, input int n);
        return (i == n - 1) ? 0 : i + 1;
    endfunction

    // a, b < n, so a single conditional subtract is enough
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b >= n) ? a + b - n : a + b;
    endfunction

endpackage

// File: rtl/arbitrate_if.sv
// Producer-side (s_*) and consumer-side (m_*) stream signals of the arbiter.
interface arbitrate_if #(
    parameter int W = 8,
    parameter int N = 2
);
    localparam int IW = arbitrate_pkg::iw(N);

    logic [N-1:0]    s_stb;
    logic [N*W-1:0]  s_dat;
    logic [N-1:0]    s_lst;
    logic [N-1:0]    s_rdy;
    logic            m_rdy;
    logic            m_stb;
    logic [IW+W-1:0] m_dat;
    logic            m_lst;

    // master: the arbiter itself; slave: the surrounding producers and consumer
    modport master (input s_stb, s_dat, s_lst, m_rdy, output s_rdy, m_stb, m_dat, m_lst);
    modport slave  (output s_stb, s_dat, s_lst, m_rdy, input s_rdy, m_stb, m_dat, m_lst);
endinterface

// File: rtl/arbitrate_rotate_encode.sv
// First-one search over the request vector, either from index 0 or rotated to start at ptr.
module rotate_encode
    import arbitrate_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic          i_rr,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    logic [IW-1:0] w_cand [N];

    for (genvar k = 0; k < N; k++) begin : g_cand
        assign w_cand[k] = i_rr ? IW'(wrap_add(int'(i_ptr), k, N)) : IW'(k);
    end

    // scan from the lowest-priority candidate so the highest-priority hit is written last
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_idx = w_cand[k];
                o_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/arbitrate.sv
// Registered N-to-1 stream arbiter with fixed/round-robin priority and packet locking.
module arbitrate
    import arbitrate_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = 2,
    parameter int RR = 1
) (
    input logic         clk,
    input logic         rst_n,
    arbitrate_if.master bus
);
    localparam int IW = iw(N);

    if (N < 2) begin : g_bad_n
        $error("arbitrate: N must be at least 2");
    end

    logic          r_lock;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] r_ptr;
    logic          r_m_stb;
    logic [IW+W-1:0] r_m_dat;
    logic          r_m_lst;

    logic [IW-1:0] w_enc_idx;
    logic          w_enc_any;
    logic [IW-1:0] w_sel;
    logic          w_gnt;
    logic          w_ld;
    logic          w_xfer;
    logic [W-1:0]  w_dat;
    logic          w_lst;

    rotate_encode #(.N(N), .IW(IW)) u_enc (
        .i_req (bus.s_stb),
        .i_ptr (r_ptr),
        .i_rr  (RR != 0),
        .o_idx (w_enc_idx),
        .o_any (w_enc_any)
    );

    // a locked owner keeps the grant even when idle, which starves everyone else
    assign w_sel  = r_lock ? r_owner : w_enc_idx;
    assign w_gnt  = r_lock ? bus.s_stb[r_owner] : w_enc_any;
    assign w_ld   = !r_m_stb || bus.m_rdy;
    assign w_xfer = w_ld && w_gnt && rst_n;
    assign w_dat  = bus.s_dat[int'(w_sel)*W +: W];
    assign w_lst  = bus.s_lst[w_sel];

    assign bus.s_rdy = w_xfer ? (N'(1) << w_sel) : '0;
    assign bus.m_stb = r_m_stb;
    assign bus.m_dat = r_m_dat;
    assign bus.m_lst = r_m_lst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_stb <= 1'b0;
            r_m_dat <= '0;
            r_m_lst <= 1'b0;
        end else if (w_ld) begin
            r_m_stb <= w_gnt;
            if (w_gnt) begin
                r_m_dat <= {w_sel, w_dat};
                r_m_lst <= w_lst;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock  <= 1'b0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            if (w_lst) begin
                r_lock <= 1'b0;
                if (RR != 0) r_ptr <= IW'(next_idx(int'(w_sel), N));
            end else begin
                r_lock  <= 1'b1;
                r_owner <= w_sel;
            end
        end
    end
endmodule

// File: tb/tb_arbitrate.sv
// Directed checks of the arbiter in fixed (N=4), round-robin (N=4) and round-robin (N=3) builds.
module tb_arbitrate;
    logic clk;
    logic rst_n;
    int   vectors = 0;
    int   errs    = 0;

    arbitrate_if #(.W(8), .N(4)) b0 ();
    arbitrate_if #(.W(8), .N(4)) b1 ();
    arbitrate_if #(.W(8), .N(3)) b2 ();

    arbitrate #(.W(8), .N(4), .RR(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
    arbitrate #(.W(8), .N(4), .RR(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));
    arbitrate #(.W(8), .N(3), .RR(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        b0.s_stb = '0; b0.s_dat = '0; b0.s_lst = '0; b0.m_rdy = 1'b1;
        b1.s_stb = '0; b1.s_dat = '0; b1.s_lst = '0; b1.m_rdy = 1'b1;
        b2.s_stb = '0; b2.s_dat = '0; b2.s_lst = '0; b2.m_rdy = 1'b1;
        #2;
        b1.s_stb = 4'b1111;
        #1;
        chk("rst_m_stb", b1.m_stb, 0);
        chk("rst_m_dat", b1.m_dat, 0);
        chk("rst_m_lst", b1.m_lst, 0);
        chk("rst_s_rdy", b1.s_rdy, 0);
        b1.s_stb = '0;
        step(); step();
        rst_n = 1'b1;

        // 1: fixed priority, ch1 always beats ch3
        b0.s_stb = 4'b1010; b0.s_lst = 4'b1111;
        b0.s_dat = {8'h33, 8'h22, 8'h11, 8'h00};
        #1;
        chk("t1_rdy0", b0.s_rdy, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t1_stb", b0.m_stb, 1);
            chk("t1_dat", b0.m_dat, 10'h111);
            chk("t1_rdy", b0.s_rdy, 4'b0010);
        end
        b0.s_stb = '0;
        step();
        chk("t1_idle_stb", b0.m_stb, 0);
        chk("t1_idle_dat", b0.m_dat, 10'h111);

        // 2: round robin sequence 0,1,2,3,0
        b1.s_stb = 4'b1111; b1.s_lst = 4'b1111;
        b1.s_dat = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_dat", b1.m_dat, ((k % 4) << 8) | (8'hA0 + (k % 4)));
        end
        b1.s_stb = '0;
        step();
        chk("t2_idle", b1.m_stb, 0);

        // 4: backpressure (ptr now 1)
        b1.s_stb = 4'b0100; b1.s_dat = {8'h00, 8'h5C, 8'h00, 8'h00};
        step();
        chk("t4_load", b1.m_dat, 10'h25C);
        b1.m_rdy = 1'b0; b1.s_dat = {8'h00, 8'h5D, 8'h00, 8'h00};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_bp_rdy", b1.s_rdy, 0);
            step();
            chk("t4_bp_dat", b1.m_dat, 10'h25C);
            chk("t4_bp_stb", b1.m_stb, 1);
            chk("t4_bp_lst", b1.m_lst, 1);
        end
        b1.m_rdy = 1'b1;
        #1;
        chk("t4_rel_rdy", b1.s_rdy, 4'b0100);
        step();
        chk("t4_drain", b1.m_dat, 10'h25D);
        b1.s_dat = {8'h00, 8'h5E, 8'h00, 8'h00};
        step();
        chk("t4_next", b1.m_dat, 10'h25E);
        b1.s_stb = '0;
        step();

        // 5: ch2 locked then idle; ch0 starved until ch2's last beat (ptr now 3)
        b1.s_stb = 4'b0100; b1.s_lst = 4'b0001;
        b1.s_dat = {8'h00, 8'h70, 8'h00, 8'h0F};
        step();
        chk("t5_first", b1.m_dat, 10'h270);
        chk("t5_first_lst", b1.m_lst, 0);
        b1.s_stb = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_starve_rdy", b1.s_rdy, 0);
            step();
            chk("t5_starve_stb", b1.m_stb, 0);
        end
        b1.s_stb = 4'b0101; b1.s_lst = 4'b0101;
        b1.s_dat = {8'h00, 8'h71, 8'h00, 8'h0F};
        #1;
        chk("t5_resume_rdy", b1.s_rdy, 4'b0100);
        step();
        chk("t5_last", b1.m_dat, 10'h271);
        chk("t5_last_lst", b1.m_lst, 1);
        step();
        chk("t5_ch0", b1.m_dat, 10'h00F);
        step();
        chk("t5_ch2", b1.m_dat, 10'h271);
        b1.s_stb = '0;
        step();

        // 3: N=3, ch0 three-beat packet holds off ch1
        b2.s_stb = 3'b011; b2.s_lst = 3'b010;
        b2.s_dat = {8'h00, 8'hD1, 8'hC1};
        #1;
        chk("t3_b1_rdy", b2.s_rdy, 3'b001);
        step();
        chk("t3_b1", b2.m_dat, 10'h0C1);
        b2.s_dat = {8'h00, 8'hD1, 8'hC2};
        #1;
        chk("t3_b2_rdy", b2.s_rdy, 3'b001);
        step();
        chk("t3_b2", b2.m_dat, 10'h0C2);
        b2.s_lst = 3'b011; b2.s_dat = {8'h00, 8'hD1, 8'hC3};
        #1;
        chk("t3_b3_rdy", b2.s_rdy, 3'b001);
        step();
        chk("t3_b3", b2.m_dat, 10'h0C3);
        #1;
        chk("t3_ch1_rdy", b2.s_rdy, 3'b010);
        step();
        chk("t3_ch1", b2.m_dat, 10'h1D1);
        b2.s_stb = '0;
        step();

        // 6: reset mid-packet on the RR build
        b1.s_stb = 4'b0010; b1.s_lst = 4'b0000;
        b1.s_dat = {8'h00, 8'h00, 8'h99, 8'h00};
        step();
        chk("t6_pre", b1.m_dat, 10'h199);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_stb", b1.m_stb, 0);
        chk("t6_rst_rdy", b1.s_rdy, 0);
        chk("t6_rst_dat", b1.m_dat, 0);
        step();
        rst_n = 1'b1;
        b1.s_stb = 4'b1111; b1.s_lst = 4'b1111;
        b1.s_dat = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        #1;
        chk("t6_tie_rdy", b1.s_rdy, 4'b0001);
        step();
        chk("t6_tie_dat", b1.m_dat, 10'h0A0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
